// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared FSM state type and range helpers for prog_counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

   typedef enum logic [0:0] {
      CNT_IDLE = 1'b0,
      CNT_RUN  = 1'b1
   } cnt_state_t;

   // Largest legal count for a given modulus, at 33 bits so MOD_VAL=2**32 fits.
   function automatic logic [32:0] cnt_max(input logic [32:0] mod_val);
      return mod_val - 33'd1;
   endfunction

   function automatic logic [32:0] clamp_load(input logic [32:0] val,
                                              input logic [32:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prog_counter_next.sv
// ============================================================================
// Module : prog_counter_next
// Brief  : Combinational next-count, limit detect and load clamp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prog_counter_next
   import counter_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter logic [32:0] MOD_VAL = 33'd256
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   input  logic             sat,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] step_val,
   output logic [WIDTH-1:0] load_clamped,
   output logic             at_end
);

   localparam logic [WIDTH:0] c_max = (WIDTH+1)'(cnt_max(MOD_VAL));

   logic [WIDTH:0] w_cnt;
   logic [WIDTH:0] w_step;

   assign w_cnt        = {1'b0, count};
   assign at_end       = up ? (w_cnt == c_max) : (w_cnt == '0);
   assign load_clamped = WIDTH'(clamp_load(33'(load_val), cnt_max(MOD_VAL)));

   always_comb begin
      w_step = w_cnt;
      if (up) begin
         w_step = at_end ? (sat ? w_cnt : '0) : (w_cnt + 1'b1);
      end else begin
         w_step = at_end ? (sat ? w_cnt : c_max) : (w_cnt - 1'b1);
      end
   end

   // The extra bit can never be set here; folding it back keeps the range hard-bounded.
   assign step_val = w_step[WIDTH] ? c_max[WIDTH-1:0] : w_step[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/prog_counter.sv
// ============================================================================
// Module : prog_counter
// Brief  : Up/down modulo counter with load, saturate mode and wrap pulse.
//          Define PROG_COUNTER_STATS_EN to add the run_cnt step counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prog_counter
   import counter_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter logic [32:0] MOD_VAL = 33'd256,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             at_end
`ifdef PROG_COUNTER_STATS_EN
   ,
   output logic [31:0]      run_cnt
`endif
);

   localparam logic [WIDTH-1:0] c_rst = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_load;
   logic             w_at_end;

   prog_counter_next #(
      .WIDTH   (WIDTH),
      .MOD_VAL (MOD_VAL)
   ) u_next (
      .count        (r_count),
      .up           (up),
      .sat          (sat),
      .load_val     (load_val),
      .step_val     (w_step),
      .load_clamped (w_load),
      .at_end       (w_at_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= c_rst;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_count <= w_load;
         r_wrap  <= 1'b0;
      end else if (enable) begin
         r_count <= w_step;
         r_wrap  <= w_at_end;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign count  = r_count;
   assign wrap   = r_wrap;
   assign at_end = w_at_end;

`ifdef PROG_COUNTER_STATS_EN
   cnt_state_t  r_state;
   cnt_state_t  w_state_nxt;
   logic [31:0] r_run_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= CNT_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CNT_IDLE: if (enable && !load)  w_state_nxt = CNT_RUN;
         CNT_RUN:  if (!enable || load)  w_state_nxt = CNT_IDLE;
         default:                        w_state_nxt = CNT_IDLE;
      endcase
   end

   // A step is counted in the cycle the FSM occupies RUN, so the first enabled edge counts too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run_cnt <= '0;
      end else if (load) begin
         r_run_cnt <= '0;
      end else if ((w_state_nxt == CNT_RUN) && (r_run_cnt != 32'hFFFF_FFFF)) begin
         r_run_cnt <= r_run_cnt + 32'd1;
      end
   end

   assign run_cnt = r_run_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_counter.sv
// ============================================================================
// Module : tb_prog_counter
// Brief  : Directed scoreboard bench for prog_counter (WIDTH=4, MOD_VAL=10).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_prog_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       up;
   logic       sat;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       wrap;
   logic       at_end;
`ifdef PROG_COUNTER_STATS_EN
   logic [31:0] run_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int step_no = 0;

   typedef struct {
      int         id;
      logic [3:0] cnt;
      logic       wrp;
      logic       ae;
   } exp_t;

   exp_t exp_q[$];

   prog_counter #(
      .WIDTH   (4),
      .MOD_VAL (33'd10),
      .RST_VAL (0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .up       (up),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .wrap     (wrap),
      .at_end   (at_end)
`ifdef PROG_COUNTER_STATS_EN
      ,
      .run_cnt  (run_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: each active edge produces one registered result to compare.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (count !== e.cnt || wrap !== e.wrp || at_end !== e.ae) begin
            bad++;
            $display("FAIL step%0d: count=%0d wrap=%0b at_end=%0b, expected count=%0d wrap=%0b at_end=%0b",
                     e.id, count, wrap, at_end, e.cnt, e.wrp, e.ae);
         end
      end
   end

   task automatic step(input logic e, input logic u, input logic s, input logic l,
                       input logic [3:0] lv, input logic [3:0] ec, input logic ew,
                       input logic ea);
      exp_t x;
      @(negedge clk);
      enable   = e;
      up       = u;
      sat      = s;
      load     = l;
      load_val = lv;
      step_no++;
      x.id  = step_no;
      x.cnt = ec;
      x.wrp = ew;
      x.ae  = ea;
      exp_q.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = 4'd0;
      @(negedge clk);
      check("reset_count", 32'(count), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Wrap-mode count up 0..9,0,1
      for (int i = 1; i <= 11; i++)
         step(1, 1, 0, 0, 4'd0, 4'(i % 10), (i == 10), ((i % 10) == 9));

      // Count down from 0 wraps to 9
      step(1, 0, 0, 1, 4'd0, 4'd0, 0, 1);
      step(1, 0, 0, 0, 4'd0, 4'd9, 1, 0);
      step(1, 0, 0, 0, 4'd0, 4'd8, 0, 0);
      step(1, 0, 0, 0, 4'd0, 4'd7, 0, 0);

      // Saturate at both ends; wrap pulses on every enabled edge at the limit
      step(1, 1, 1, 1, 4'd8, 4'd8, 0, 0);
      step(1, 1, 1, 0, 4'd0, 4'd9, 0, 1);
      step(1, 1, 1, 0, 4'd0, 4'd9, 1, 1);
      step(1, 1, 1, 0, 4'd0, 4'd9, 1, 1);
      step(0, 1, 1, 0, 4'd0, 4'd9, 0, 1);
      step(0, 0, 1, 1, 4'd0, 4'd0, 0, 1);
      step(1, 0, 1, 0, 4'd0, 4'd0, 1, 1);

      // Load overrides enable, clamps, then direction changes mid-run
      step(1, 1, 0, 1, 4'd7,  4'd7, 0, 0);
      step(1, 1, 0, 1, 4'd15, 4'd9, 0, 1);
      step(1, 0, 0, 0, 4'd0,  4'd8, 0, 0);
      step(1, 1, 0, 0, 4'd0,  4'd9, 0, 1);
      step(1, 1, 0, 0, 4'd0,  4'd0, 1, 0);

      // Asynchronous reset between edges at count=5
      step(0, 1, 0, 1, 4'd4, 4'd4, 0, 0);
      step(1, 1, 0, 0, 4'd0, 4'd5, 0, 0);
      @(negedge clk);
      #2;
      reset  = 1'b1;
      enable = 1'b1;
      #1;
      check("async_reset_count", 32'(count), 32'd0);
      check("async_reset_wrap", 32'(wrap), 32'd0);
      @(posedge clk);
      #1;
      check("reset_held_count", 32'(count), 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;
      step(1, 1, 0, 0, 4'd0, 4'd1, 0, 0);
      step(1, 1, 0, 0, 4'd0, 4'd2, 0, 0);

`ifdef PROG_COUNTER_STATS_EN
      step(0, 1, 0, 1, 4'd0, 4'd0, 0, 0);
      for (int k = 1; k <= 20; k++)
         step(1, 1, 0, 0, 4'd0, 4'(k % 10), ((k % 10) == 0), ((k % 10) == 9));
      for (int k = 0; k < 5; k++)
         step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0);
      for (int k = 1; k <= 3; k++)
         step(1, 1, 0, 0, 4'd0, 4'(k), 0, 0);
      @(negedge clk);
      enable = 1'b0;
      check("run_cnt_23", run_cnt, 32'd23);
      step(0, 1, 0, 1, 4'd2, 4'd2, 0, 0);
      @(negedge clk);
      check("run_cnt_load_clear", run_cnt, 32'd0);
`endif

      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
